// File: rtl/ara_pkg.sv
// Shared constants and helpers for the Ara cluster dispatch logic.
package ara_pkg;

  localparam int unsigned DefaultMaxOutstanding = 4;

  // Width of a counter that must represent 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/ara_stream_fork.sv
// Generic valid/ready fork over N outputs; a done mask prevents duplicate delivery
// to outputs that accepted before the others.
module ara_stream_fork
  import ara_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] valid_o,
  input  logic [N-1:0] ready_i
);

  logic [N-1:0] r_done;
  logic [N-1:0] w_done_d;
  logic [N-1:0] w_hs;

  always_comb begin
    valid_o  = {N{valid_i}} & ~r_done;
    w_hs     = valid_o & ready_i;
    ready_o  = valid_i && (&(r_done | w_hs));
    w_done_d = ready_o ? '0 : (r_done | w_hs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= '0;
    end else begin
      r_done <= w_done_d;
    end
  end

endmodule

// File: rtl/ara_grp_dispatch.sv
// Broadcast/join between the core accelerator port and NrGroups Ara instances.
// Define ARA_GRP_RESP_CHECK_EN to add the sticky err_o response-mismatch flag.
module ara_grp_dispatch
  import ara_pkg::*;
#(
  parameter int unsigned NrGroups       = 4,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter type         req_t          = logic,
  parameter type         resp_t         = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  req_t                       req_i,
  output logic  [NrGroups-1:0]       grp_req_valid_o,
  input  logic  [NrGroups-1:0]       grp_req_ready_i,
  output req_t                       grp_req_o,
  input  logic  [NrGroups-1:0]       grp_resp_valid_i,
  output logic  [NrGroups-1:0]       grp_resp_ready_o,
  input  resp_t [NrGroups-1:0]       grp_resp_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output resp_t                      resp_o
`ifdef ARA_GRP_RESP_CHECK_EN
  ,
  output logic                       err_o
`endif
);

  localparam int unsigned    CntW   = cnt_width(MaxOutstanding);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_full;
  logic            w_fork_valid;
  logic            w_fire;
  logic            w_pop;

  assign w_full       = (r_cnt == MaxCnt);
  assign w_fork_valid = req_valid_i && !w_full;
  assign req_ready_o  = w_fire;
  assign grp_req_o    = req_i;

  ara_stream_fork #(
    .N (NrGroups)
  ) u_fork (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (w_fork_valid),
    .ready_o (w_fire),
    .valid_o (grp_req_valid_o),
    .ready_i (grp_req_ready_i)
  );

  // A response with nothing outstanding is held off rather than popped.
  assign resp_valid_o     = (&grp_resp_valid_i) && (r_cnt != '0);
  assign w_pop            = resp_valid_o && resp_ready_i;
  assign grp_resp_ready_o = {NrGroups{w_pop}};
  assign resp_o           = grp_resp_i[0];

  always_comb begin
    w_cnt_d = r_cnt;
    unique case ({w_fire, w_pop})
      2'b10:   w_cnt_d = r_cnt + CntW'(1);
      2'b01:   w_cnt_d = r_cnt - CntW'(1);
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

`ifdef ARA_GRP_RESP_CHECK_EN
  logic w_mismatch;
  logic r_err;

  always_comb begin
    w_mismatch = 1'b0;
    for (int unsigned g = 1; g < NrGroups; g++) begin
      w_mismatch = w_mismatch | (grp_resp_i[g] != grp_resp_i[0]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_pop && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

  assert property (@(posedge clk_i) disable iff (!rst_ni) w_pop |-> !w_mismatch)
    else $error("ara_grp_dispatch: group responses disagree on pop");
`else
  resp_t [NrGroups-1:0] w_unused_resp;
  assign w_unused_resp = grp_resp_i;
`endif

endmodule

// File: tb/tb_ara_grp_dispatch.sv
// Directed checks of the dispatch corner cases followed by a randomized run
// scored against a transaction-level model of the groups and the upstream.
module tb_ara_grp_dispatch;

  localparam int unsigned NG      = 4;
  localparam int unsigned MAX_OUT = 4;
  typedef logic [15:0] data_t;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  data_t            req;
  logic [NG-1:0]    grp_req_valid;
  logic [NG-1:0]    grp_req_ready;
  data_t            grp_req;
  logic [NG-1:0]    grp_resp_valid;
  logic [NG-1:0]    grp_resp_ready;
  data_t [NG-1:0]   grp_resp;
  logic             resp_valid;
  logic             resp_ready;
  data_t            resp;

  int total;
  int bad;
  bit mon_en;

  // Scoreboard: per-group expected deliveries, expected joined responses, and
  // per-group queues of requests each modelled group holds awaiting response.
  data_t exp_grp[NG][$];
  data_t exp_resp[$];
  data_t gq[NG][$];
  logic [NG-1:0] delivered;
  int outstanding;

  ara_grp_dispatch #(
    .NrGroups       (NG),
    .MaxOutstanding (MAX_OUT),
    .req_t          (data_t),
    .resp_t         (data_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_i            (req),
    .grp_req_valid_o  (grp_req_valid),
    .grp_req_ready_i  (grp_req_ready),
    .grp_req_o        (grp_req),
    .grp_resp_valid_i (grp_resp_valid),
    .grp_resp_ready_o (grp_resp_ready),
    .grp_resp_i       (grp_resp),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_o           (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic data_t resp_of(input data_t x);
    return data_t'(x * 3 + 16'h0101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT behaviour against the transaction model each cycle.
  logic [NG-1:0] m_egv;
  logic [NG-1:0] m_hs;
  bit            m_full, m_fire, m_rv, m_pop;
  data_t         m_e;

  always @(negedge clk) begin
    if (mon_en) begin
      m_full = (outstanding >= MAX_OUT);
      for (int g = 0; g < NG; g++) m_egv[g] = req_valid && !m_full && !delivered[g];
      check("grp_req_valid", 32'(grp_req_valid), 32'(m_egv));
      m_hs = m_egv & grp_req_ready;
      for (int g = 0; g < NG; g++) begin
        if (m_hs[g]) begin
          if (exp_grp[g].size() == 0) begin
            total++;
            bad++;
            $display("FAIL grp_handoff: group %0d got %h expected no request", g, grp_req);
          end else begin
            m_e = exp_grp[g].pop_front();
            check("grp_req_data", 32'(grp_req), 32'(m_e));
            gq[g].push_back(m_e);
          end
          delivered[g] = 1'b1;
        end
      end
      m_fire = req_valid && !m_full && (&delivered);
      check("req_ready", 32'(req_ready), 32'(m_fire));
      m_rv = (&grp_resp_valid) && (outstanding > 0);
      check("resp_valid", 32'(resp_valid), 32'(m_rv));
      m_pop = m_rv && resp_ready;
      check("grp_resp_ready", 32'(grp_resp_ready), 32'({NG{m_pop}}));
      if (m_pop) begin
        if (exp_resp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_data: got %h expected no response", resp);
        end else begin
          check("resp_data", 32'(resp), 32'(exp_resp.pop_front()));
        end
        for (int g = 0; g < NG; g++) if (gq[g].size() > 0) void'(gq[g].pop_front());
      end
      if (m_fire) delivered = '0;
      outstanding = outstanding + int'(m_fire) - int'(m_pop);
    end
  end

  // One randomized cycle of upstream and group behaviour.
  task automatic drive_cycle(input bit allow_issue, input int unsigned slow);
    bit acc;
    @(negedge clk);
    #2;
    acc = req_valid && req_ready;
    @(posedge clk);
    #1;
    if (acc) req_valid = 1'b0;
    if (allow_issue && !req_valid && $urandom_range(0, 3) != 0) begin
      req       = data_t'($urandom);
      req_valid = 1'b1;
      for (int g = 0; g < NG; g++) exp_grp[g].push_back(req);
      exp_resp.push_back(resp_of(req));
    end
    grp_req_ready = NG'($urandom);
    resp_ready    = ($urandom_range(0, 3) != 0);
    for (int g = 0; g < NG; g++) begin
      grp_resp_valid[g] = (gq[g].size() > 0) && ($urandom_range(0, slow) == 0);
      grp_resp[g] = (gq[g].size() > 0) ? (resp_of(gq[g][0]) ^ data_t'(g * 16'h1111))
                                       : data_t'($urandom);
    end
  endtask

  logic [NG-1:0] st_rdy[6];
  logic [NG-1:0] st_gv[6];
  int            hs_cnt[NG];
  int            guard;
  int            issued;

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req = '0;
    grp_req_ready = '0;
    grp_resp_valid = '0;
    resp_ready = 1'b0;
    grp_resp = '0;
    delivered = '0;
    outstanding = 0;
    st_rdy = '{4'h1, 4'h0, 4'h2, 4'h4, 4'h0, 4'h8};
    st_gv  = '{4'hF, 4'hE, 4'hE, 4'hC, 4'h8, 4'h8};

    #3;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grp_req_valid", 32'(grp_req_valid), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_grp_resp_ready", 32'(grp_resp_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request, all groups ready: completes in the same cycle.
    req_valid = 1'b1;
    req = 16'h1111;
    grp_req_ready = 4'hF;
    #1;
    check("single_req_ready", 32'(req_ready), 1);
    check("single_grp_valid", 32'(grp_req_valid), 32'hF);
    check("single_grp_req", 32'(grp_req), 32'h1111);
    tick();
    req_valid = 1'b0;
    grp_req_ready = '0;
    grp_resp_valid = 4'hF;
    grp_resp = {16'h00AA, 16'h00BB, 16'h00CC, 16'h00C3};
    resp_ready = 1'b1;
    #1;
    check("join_resp_valid", 32'(resp_valid), 1);
    check("join_resp_data", 32'(resp), 32'h00C3);
    check("join_grp_resp_ready", 32'(grp_resp_ready), 32'hF);
    tick();
    check("empty_hold_off_valid", 32'(resp_valid), 0);
    check("empty_hold_off_ready", 32'(grp_resp_ready), 0);
    grp_resp_valid = '0;

    // Staggered group readiness.
    req_valid = 1'b1;
    req = 16'h2222;
    for (int g = 0; g < NG; g++) hs_cnt[g] = 0;
    for (int c = 0; c < 6; c++) begin
      grp_req_ready = st_rdy[c];
      #1;
      check($sformatf("stagger_gv_c%0d", c), 32'(grp_req_valid), 32'(st_gv[c]));
      check($sformatf("stagger_rdy_c%0d", c), 32'(req_ready), (c == 5) ? 1 : 0);
      for (int g = 0; g < NG; g++) hs_cnt[g] += int'(grp_req_valid[g] & grp_req_ready[g]);
      tick();
    end
    req_valid = 1'b0;
    grp_req_ready = '0;
    for (int g = 0; g < NG; g++) check($sformatf("stagger_hs_g%0d", g), 32'(hs_cnt[g]), 1);

    // Fill to MaxOutstanding, then the next request stalls until a pop.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req = data_t'(16'h3000 + i);
      grp_req_ready = 4'hF;
      #1;
      check("fill_req_ready", 32'(req_ready), 1);
      tick();
    end
    req = 16'h4444;
    #1;
    check("full_req_ready", 32'(req_ready), 0);
    check("full_grp_valid", 32'(grp_req_valid), 0);
    grp_resp_valid = 4'hF;
    resp_ready = 1'b1;
    #1;
    check("full_pop_valid", 32'(resp_valid), 1);
    check("full_pop_no_fire", 32'(req_ready), 0);
    tick();
    grp_resp_valid = '0;
    #1;
    check("released_req_ready", 32'(req_ready), 1);
    tick();
    #1;
    check("refull_req_ready", 32'(req_ready), 0);
    req_valid = 1'b0;

    // Three of four responses: no join.
    grp_resp_valid = 4'h7;
    #1;
    check("partial_resp_valid", 32'(resp_valid), 0);
    check("partial_grp_resp_ready", 32'(grp_resp_ready), 0);
    grp_resp_valid = 4'hF;
    tick();
    tick();
    // Fire and pop together at two outstanding.
    req_valid = 1'b1;
    req = 16'h5555;
    grp_req_ready = 4'hF;
    #1;
    check("fp_req_ready", 32'(req_ready), 1);
    check("fp_resp_valid", 32'(resp_valid), 1);
    tick();
    grp_resp_valid = '0;
    #1;
    check("fp_after_1", 32'(req_ready), 1);
    tick();
    #1;
    check("fp_after_2", 32'(req_ready), 1);
    tick();
    #1;
    check("fp_after_full", 32'(req_ready), 0);
    req_valid = 1'b0;
    grp_req_ready = '0;
    grp_resp_valid = 4'hF;
    repeat (4) tick();
    check("drained_resp_valid", 32'(resp_valid), 0);
    grp_resp_valid = '0;

    // Reset while a request is half forked.
    req_valid = 1'b1;
    req = 16'h6666;
    grp_req_ready = 4'h3;
    #1;
    check("prerst_gv", 32'(grp_req_valid), 32'hF);
    tick();
    grp_req_ready = '0;
    #1;
    check("partial_gv", 32'(grp_req_valid), 32'hC);
    rst_n = 1'b0;
    #1;
    check("midrst_gv", 32'(grp_req_valid), 32'hF);
    check("midrst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    grp_req_ready = 4'hF;
    #1;
    check("represent_gv", 32'(grp_req_valid), 32'hF);
    check("represent_req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    grp_req_ready = '0;

    // Randomized phase under the scoreboard.
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    delivered = '0;
    outstanding = 0;
    mon_en = 1'b1;
    issued = 0;
    for (int c = 0; c < 1500; c++) begin
      drive_cycle(1'b1, (c < 600) ? 6 : 1);
    end
    guard = 0;
    while ((exp_resp.size() > 0 || req_valid) && guard < 3000) begin
      drive_cycle(1'b0, 1);
      guard++;
    end
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    check("drain_resp_queue", 32'(exp_resp.size()), 0);
    for (int g = 0; g < NG; g++) check("drain_grp_queue", 32'(exp_grp[g].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ara_grp_dispatch.md
# ara_grp_dispatch

Broadcast and join stage placed between the scalar core's accelerator port and the NrGroups Ara instances of the cluster. It forks each accepted request to every group with independent per-group handshakes, joins the per-group responses into a single response, and returns group 0's payload. It also bounds the number of dispatched requests still waiting for a joined response.

## Interface
Parameters:
- NrGroups, 4, number of Ara instances. Legal range 1..16.
- MaxOutstanding, 4, maximum number of dispatched requests still awaiting a joined response. Must be at least 1.
- req_t, logic, request payload type. Broadcast unchanged.
- resp_t, logic, response payload type.

Ports. One clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request accepted.
- req_i  in  req_t  upstream request payload.
- grp_req_valid_o  out  NrGroups  per-group request valid.
- grp_req_ready_i  in  NrGroups  per-group request ready.
- grp_req_o  out  req_t  request payload shared by all groups; equals req_i.
- grp_resp_valid_i  in  NrGroups  per-group response valid.
- grp_resp_ready_o  out  NrGroups  per-group response pop.
- grp_resp_i  in  NrGroups×resp_t  per-group response payloads.
- resp_valid_o  out  1  joined response valid.
- resp_ready_i  in  1  upstream takes the joined response.
- resp_o  out  resp_t  joined payload, equal to grp_resp_i[0].
- err_o  out  1  sticky response-mismatch flag. Present only when the configuration macro below is defined.

## Operation
- State: done_q[NrGroups], an accepted-this-request mask; cnt_q, the outstanding counter, width $clog2(MaxOutstanding+1).
- Fork, active when req_valid_i && cnt_q < MaxOutstanding:
  - grp_req_valid_o[g] = ~done_q[g].
  - Group g hands off when grp_req_valid_o[g] && grp_req_ready_i[g].
- fire = (done_q | per-group hand-off) is all ones.
  - req_ready_o = fire.
  - On fire, done_q is cleared to 0.
  - Without fire, done_q |= hand-off.
- When cnt_q == MaxOutstanding (full):
  - grp_req_valid_o is 0 and req_ready_o is 0.
  - done_q holds its value.
- req_valid_i must stay high with stable req_i until req_ready_o is seen. The block does not check this.
- Join:
  - resp_valid_o = &grp_resp_valid_i && cnt_q != 0.
  - grp_resp_ready_o[g] = resp_valid_o && resp_ready_i, for every g together.
  - pop = resp_valid_o && resp_ready_i.
- Counter update:
  - fire only: cnt_q + 1.
  - pop only: cnt_q − 1.
  - fire and pop in the same cycle: unchanged.
  - Never wraps.
- A response arriving while cnt_q == 0 is not acknowledged. It is held off and not popped.
- NrGroups == 1 degenerates to a pass-through with the counter still enforced.

## Timing
- Reset values:
  - done_q = 0, cnt_q = 0.
  - req_ready_o = 0 unless the fire condition holds combinationally.
  - grp_req_valid_o follows req_valid_i (zero while req_valid_i is low).
  - resp_valid_o = 0, grp_resp_ready_o = 0, err_o = 0.
- Fork and join are combinational, with zero added latency. When all groups are ready, a request completes in the same cycle it is presented.
- A group that accepted early sees grp_req_valid_o low from the next cycle until the request completes. No duplicate delivery.
- Reset asserted mid-request:
  - done_q and cnt_q clear immediately.
  - Any partially forked request is dropped.
  - The upstream must re-present it.

## Configuration
- ARA_GRP_RESP_CHECK_EN defined:
  - On every pop, grp_resp_i[g] is compared with grp_resp_i[0] for g ≥ 1.
  - Any difference sets err_o, which is sticky until reset.
  - A simulation-only assertion fires in the same cycle.
- Not defined:
  - The port err_o does not exist.
  - There is no comparison logic.

## Structure
- The shared package ara_pkg holds:
  - the outstanding-counter width helper;
  - the default MaxOutstanding constant.
- One sub-module, ara_stream_fork. It implements the done-mask fork generically over N outputs.
- Join, counter and check logic stay in the top module.

## Test plan
- NrGroups=4, all ready, one request → req_ready_o=1 in the same cycle, cnt_q=1. Then all four responses valid with resp_ready_i=1 → resp_valid_o=1, cnt_q=0, resp_o equals group 0's payload.
- Groups ready staggered at cycles 0, 2, 3, 5 → each group's valid drops after its own hand-off. req_ready_o pulses only at cycle 5. Each group sees exactly one hand-off.
- Five requests with MaxOutstanding=4 and no responses → the fifth stalls: grp_req_valid_o=0, req_ready_o=0. One pop releases it in the next cycle, and cnt_q returns to 4.
- Fire and pop in the same cycle at cnt_q=2 → cnt_q stays at 2.
- Only 3 of 4 responses valid → resp_valid_o=0 and no grp_resp_ready_o is asserted.
- Reset asserted after 2 of 4 groups accepted → done_q=0 and cnt_q=0. On re-presentation all 4 groups see valid again. With ARA_GRP_RESP_CHECK_EN defined, mismatching group 2 on a pop → err_o=1 and it stays set.
